alu_share_arb: RTL and testbench
================================

# alu_share_arb

Round-robin arbiter and sequencer that shares one `myALU` instance between `N_REQ` requesters, for example the execute stage and an address-generation unit. Each requester issues an operation with a valid/ready handshake. The block latches the winning operands, runs the ALU for one cycle, and returns a registered result with a second valid/ready handshake. It sits between the issue logic and the single combinational ALU, so the ALU sees only stable, registered operands.

## Interface
- `N_REQ`, default 2, number of requesters (1..8).
- `PTR_W`, default `$clog2(N_REQ)` (minimum 1), width of the round-robin pointer and owner index.
- `clk` in, 1, single clock; all state updates on the rising edge.
- `rst_n` in, 1, asynchronous active-low reset.
- `req_valid` in, `N_REQ`, per-requester operation valid.
- `req_ready` out, `N_REQ`, one-hot grant/accept, or all zero.
- `req_a` in, `N_REQ*32`, operand A per requester (slice i = bits `[32i+31:32i]`).
- `req_b` in, `N_REQ*32`, operand B per requester.
- `req_op` in, `N_REQ*4`, ALU opcode per requester.
- `req_shamt` in, `N_REQ*5`, shift amount per requester.
- `rsp_valid` out, `N_REQ`, one-hot response valid to the owning requester.
- `rsp_ready` in, `N_REQ`, per-requester response accept.
- `rsp_result` out, 32, registered ALU result.
- `rsp_overflow` out, 1, registered ALU overflow.
- `rsp_zero` out, 1, registered ALU zero flag.
- `rsp_err` out, 1, illegal-opcode flag; tied 0 unless `ALU_ARB_OPCHECK_EN` is defined.

## Operation
- Opcodes:
  - 0 add
  - 1 sub
  - 2 and
  - 3 or
  - 4 sll
  - 5 srl
  - 6 sra
  - 7 set-if-A>B (signed)
  - 8 set-if-A<B (signed)
  - 9..15 illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is high, the winner is the first set bit found by searching upward from `ptr`, wrapping at `N_REQ-1` to 0.
  - `req_ready[winner]` is driven combinationally high in that cycle.
  - On the edge, the block latches the winner's a/b/op/shamt and owner index, then moves to EXEC.
  - If no `req_valid` is high, it stays in IDLE.
- EXEC:
  - The ALU inputs are driven from the latched operand registers.
  - On the edge, the block captures result, overflow and zero into the response registers, then moves to RESP.
- RESP:
  - `rsp_valid[owner]` is high.
  - When `rsp_ready[owner]` is high on an edge, the block sets `ptr <= (owner+1) mod N_REQ` and returns to IDLE.
  - `rsp_ready` bits of non-owners are ignored.
- `req_ready` is all zero outside IDLE.
- A requester holds `req_valid` and its payload stable until it sees `req_ready`. Deasserting `req_valid` before the grant is legal; that requester is simply not selected.
- The response payload stays stable for as long as `rsp_valid` is high.
- Width rules:
  - All arithmetic is 32-bit two's complement, with the ALU's overflow and zero semantics.
  - Only `shamt[4:0]` is used; it is ignored for ops 0..3, 7 and 8.
- With `N_REQ=1`, `ptr` is constant 0 and behaviour is otherwise identical.

## Timing
- Reset values:
  - state = IDLE, `ptr` = 0, owner = 0.
  - `req_ready` = 0, `rsp_valid` = 0.
  - `rsp_result` = 0, `rsp_overflow` = 0, `rsp_zero` = 0, `rsp_err` = 0.
  - Operand registers = 0.
- Latency: request accepted in cycle T; `rsp_valid` is high from cycle T+2.
- Throughput: minimum 3 cycles per operation (accept, execute, response with immediate `rsp_ready`). The next grant cannot occur before the cycle after the response handshake.
- Backpressure: `rsp_ready` held low keeps the block in RESP indefinitely, and no new requests are accepted meanwhile.
- Simultaneous requests: exactly one grant per IDLE cycle; losers keep `req_valid` high and win in later rounds in round-robin order.
- Reset asserted mid-operation: the in-flight operation is discarded with no response, all outputs return to reset values asynchronously, and `ptr` returns to 0.

## Configuration
- `ALU_ARB_OPCHECK_EN` defined:
  - In EXEC, an opcode of 9..15 bypasses the ALU.
  - The response is `rsp_result=0`, `rsp_overflow=0`, `rsp_zero=1`, `rsp_err=1`, with the same latency.
  - `rsp_err` is 0 for legal opcodes.
- `ALU_ARB_OPCHECK_EN` undefined:
  - The opcode passes to the ALU unchecked, and `rsp_err` is constant 0.
  - Illegal opcodes return whatever the ALU produces (X in simulation).

## Structure
- Shared package `alu_pkg`:
  - Opcode constants `ALU_ADD`..`ALU_SLT` (0..8) and `ALU_OP_LAST` = 8.
  - FSM state typedef (IDLE/EXEC/RESP).
  - Data width constant 32.
- Sub-module `alu_rr_pick`: combinational round-robin picker. Inputs are the `N_REQ` request vector and `ptr`; outputs are a one-hot grant and the grant index.
- The `myALU` instance lives inside `alu_share_arb`, fed from the operand registers.

## Test plan
- Requester 0 sends add, A=8, B=7 → grant at T, `rsp_valid[0]` at T+2, result=15, overflow=0, zero=0.
- Requesters 0 and 1 both send continuously from reset:
  - Grant order is 0,1,0,1.
  - Requester 1 sends sub, A=5, B=5 → result=0, zero=1.
- Requester 1 sends add, A=0x7FFFFFFF, B=1 → result 0x80000000, overflow=1.
- Requester 0 sends sra, A=0x80000000, shamt=4, with `rsp_ready` held low for 5 cycles:
  - result 0xF8000000 stays stable.
  - `req_ready` stays 0 throughout, even with requester 1 valid.
- Reset pulsed during EXEC → no `rsp_valid` afterwards, all outputs 0, next grant goes to requester 0.
- With `ALU_ARB_OPCHECK_EN`, op=12 → result=0, zero=1, `rsp_err`=1 at T+2. Without the macro, `rsp_err` stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: data width, ALU opcodes,
// sequencer states and an opcode legality helper.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int SHAMT_W = 5;

  localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [OP_W-1:0] ALU_SLL = 4'd4;
  localparam logic [OP_W-1:0] ALU_SRL = 4'd5;
  localparam logic [OP_W-1:0] ALU_SRA = 4'd6;
  localparam logic [OP_W-1:0] ALU_SGT = 4'd7;
  localparam logic [OP_W-1:0] ALU_SLT = 4'd8;
  localparam logic [OP_W-1:0] ALU_OP_LAST = ALU_SLT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op <= ALU_OP_LAST);
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// ptr with wrap-around; returns a one-hot grant and its index.
module alu_rr_pick #(
  parameter int N_REQ = 2,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // ptr and k are both below N_REQ, so one conditional subtract wraps.
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N_REQ))
        sum = sum - (PTR_W+1)'(N_REQ);
      idx = sum[PTR_W-1:0];
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/myALU.sv
// Single-cycle combinational 32-bit ALU shared by the arbiter.
// Overflow is signed overflow for add/sub only; zero flags an all-zero result.
module myALU
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [OP_W-1:0]    op,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  result,
  output logic               overflow,
  output logic               zero
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        result   = sum;
        overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      ALU_SRA: result = $unsigned($signed(a) >>> shamt);
      ALU_SGT: result = {{(DATA_W-1){1'b0}}, ($signed(a) > $signed(b))};
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: begin
        // Illegal opcodes are don't-care for the datapath.
        result   = 'x;
        overflow = 1'bx;
      end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sequencer sharing one myALU between N_REQ requesters.
// Optional ALU_ARB_OPCHECK_EN: illegal opcodes bypass the ALU and raise rsp_err.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*DATA_W-1:0]    req_a,
  input  logic [N_REQ*DATA_W-1:0]    req_b,
  input  logic [N_REQ*OP_W-1:0]      req_op,
  input  logic [N_REQ*SHAMT_W-1:0]   req_shamt,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [DATA_W-1:0]          rsp_result,
  output logic                       rsp_overflow,
  output logic                       rsp_zero,
  output logic                       rsp_err
);

  arb_state_t state_reg, state_next;
  logic [PTR_W-1:0]   ptr_reg, owner_reg, ptr_wrap;
  logic [DATA_W-1:0]  a_reg, b_reg;
  logic [OP_W-1:0]    op_reg;
  logic [SHAMT_W-1:0] shamt_reg;
  logic [DATA_W-1:0]  result_reg;
  logic               overflow_reg, zero_reg, err_reg;

  logic [DATA_W-1:0]  a_arr     [N_REQ];
  logic [DATA_W-1:0]  b_arr     [N_REQ];
  logic [OP_W-1:0]    op_arr    [N_REQ];
  logic [SHAMT_W-1:0] shamt_arr [N_REQ];

  logic [N_REQ-1:0] pick_grant;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic             accept, release_rsp;

  logic [DATA_W-1:0] alu_result, exec_result;
  logic              alu_overflow, alu_zero;
  logic              exec_overflow, exec_zero, exec_err;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign a_arr[gi]     = req_a[gi*DATA_W +: DATA_W];
      assign b_arr[gi]     = req_b[gi*DATA_W +: DATA_W];
      assign op_arr[gi]    = req_op[gi*OP_W +: OP_W];
      assign shamt_arr[gi] = req_shamt[gi*SHAMT_W +: SHAMT_W];
      assign rsp_valid[gi] = (state_reg == RESP) && (owner_reg == PTR_W'(gi));
    end
  endgenerate

  alu_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  myALU u_alu (
    .a        (a_reg),
    .b        (b_reg),
    .op       (op_reg),
    .shamt    (shamt_reg),
    .result   (alu_result),
    .overflow (alu_overflow),
    .zero     (alu_zero)
  );

`ifdef ALU_ARB_OPCHECK_EN
  logic op_illegal;
  assign op_illegal    = !is_legal_op(op_reg);
  assign exec_result   = op_illegal ? '0 : alu_result;
  assign exec_overflow = op_illegal ? 1'b0 : alu_overflow;
  assign exec_zero     = op_illegal ? 1'b1 : alu_zero;
  assign exec_err      = op_illegal;
`else
  assign exec_result   = alu_result;
  assign exec_overflow = alu_overflow;
  assign exec_zero     = alu_zero;
  assign exec_err      = 1'b0;
`endif

  // Next owner after the current one; collapses to constant 0 when N_REQ is 1.
  assign ptr_wrap = (owner_reg == PTR_W'(N_REQ-1)) ? '0 : owner_reg + 1'b1;

  always_comb begin
    state_next  = state_reg;
    req_ready   = '0;
    accept      = 1'b0;
    release_rsp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          req_ready  = pick_grant;
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_ready[owner_reg]) begin
          release_rsp = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      shamt_reg    <= '0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg     <= a_arr[pick_idx];
        b_reg     <= b_arr[pick_idx];
        op_reg    <= op_arr[pick_idx];
        shamt_reg <= shamt_arr[pick_idx];
        owner_reg <= pick_idx;
      end
      if (state_reg == EXEC) begin
        result_reg   <= exec_result;
        overflow_reg <= exec_overflow;
        zero_reg     <= exec_zero;
        err_reg      <= exec_err;
      end
      if (release_rsp)
        ptr_reg <= ptr_wrap;
    end
  end

  assign rsp_result   = result_reg;
  assign rsp_overflow = overflow_reg;
  assign rsp_zero     = zero_reg;
  assign rsp_err      = err_reg;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb with two requesters.
module tb_alu_share_arb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_op;
  logic [9:0]  req_shamt;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_overflow;
  logic        rsp_zero;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  alu_share_arb #(.N_REQ(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .req_shamt    (req_shamt),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_zero     (rsp_zero),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [4:0] sh);
    req_a[i*32 +: 32]    = a;
    req_b[i*32 +: 32]    = b;
    req_op[i*4 +: 4]     = op;
    req_shamt[i*5 +: 5]  = sh;
    req_valid[i]         = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    req_a = '0; req_b = '0; req_op = '0; req_shamt = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", rsp_result); end
    checks++; if (rsp_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", rsp_overflow); end
    checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b exp 0", rsp_zero); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", rsp_err); end
    rst_n = 1'b1;
    $display("reset: done");
  endtask

  task automatic test_add;
    @(negedge clk);
    set_req(0, 32'd8, 32'd7, 4'd0, 5'd0); rsp_ready = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL add_grant got %b exp 01", req_ready); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL add_t1_valid got %b exp 00", rsp_valid); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL add_t1_ready got %b exp 00", req_ready); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL add_t2_valid got %b exp 01", rsp_valid); end
    checks++; if (rsp_result !== 32'd15) begin errors++; $display("FAIL add_result got %h exp 0000000f", rsp_result); end
    checks++; if (rsp_overflow !== 1'b0) begin errors++; $display("FAIL add_ovf got %b exp 0", rsp_overflow); end
    checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL add_zero got %b exp 0", rsp_zero); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL add_err got %b exp 0", rsp_err); end
    $display("add: 8+7 result=%h", rsp_result);
  endtask

  task automatic test_round_robin;
    logic [1:0]  exp_g;
    logic [31:0] exp_r;
    logic        exp_z;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    rsp_ready = 2'b11;
    for (int r = 0; r < 4; r++) begin
      exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
      exp_r = (r % 2 == 0) ? 32'd3 : 32'd0;
      exp_z = (r % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (r == 0) begin
        set_req(0, 32'd1, 32'd2, 4'd0, 5'd0);
        set_req(1, 32'd5, 32'd5, 4'd1, 5'd0);
      end
      #1;
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", r, req_ready, exp_g); end
      repeat (2) @(negedge clk);
      #1;
      checks++; if (rsp_valid !== exp_g) begin errors++; $display("FAIL rr_valid%0d got %b exp %b", r, rsp_valid, exp_g); end
      checks++; if (rsp_result !== exp_r) begin errors++; $display("FAIL rr_result%0d got %h exp %h", r, rsp_result, exp_r); end
      checks++; if (rsp_zero !== exp_z) begin errors++; $display("FAIL rr_zero%0d got %b exp %b", r, rsp_zero, exp_z); end
      checks++; if (rsp_overflow !== 1'b0) begin errors++; $display("FAIL rr_ovf%0d got %b exp 0", r, rsp_overflow); end
      $display("round_robin: round %0d grant=%b result=%h zero=%b", r, req_ready, rsp_result, rsp_zero);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_overflow;
    @(negedge clk);
    set_req(1, 32'h7FFF_FFFF, 32'd1, 4'd0, 5'd0); rsp_ready = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL ovf_grant got %b exp 10", req_ready); end
    @(negedge clk); req_valid[1] = 1'b0;
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL ovf_valid got %b exp 10", rsp_valid); end
    checks++; if (rsp_result !== 32'h8000_0000) begin errors++; $display("FAIL ovf_result got %h exp 80000000", rsp_result); end
    checks++; if (rsp_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", rsp_overflow); end
    checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL ovf_zero got %b exp 0", rsp_zero); end
    $display("overflow: 7fffffff+1 result=%h ovf=%b", rsp_result, rsp_overflow);
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    set_req(0, 32'h8000_0000, 32'd0, 4'd6, 5'd4); rsp_ready = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_grant got %b exp 01", req_ready); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    set_req(1, 32'h0000_00F0, 32'h0000_000F, 4'd3, 5'd0);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_exec_ready got %b exp 00", req_ready); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL bp_valid%0d got %b exp 01", c, rsp_valid); end
      checks++; if (rsp_result !== 32'hF800_0000) begin errors++; $display("FAIL bp_result%0d got %h exp f8000000", c, rsp_result); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got %b exp 00", c, req_ready); end
    end
    rsp_ready = 2'b11;
    @(negedge clk); #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_next_grant got %b exp 10", req_ready); end
    @(negedge clk); req_valid[1] = 1'b0;
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL bp_or_valid got %b exp 10", rsp_valid); end
    checks++; if (rsp_result !== 32'h0000_00FF) begin errors++; $display("FAIL bp_or_result got %h exp 000000ff", rsp_result); end
    $display("backpressure: sra held 5 cycles, then or result=%h", rsp_result);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    set_req(0, 32'd6, 32'd5, 4'd2, 5'd0); rsp_ready = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_grant_a got %b exp 01", req_ready); end
    @(negedge clk); req_valid[0] = 1'b0;
    @(negedge clk); #1;
    checks++; if (rsp_result !== 32'd4) begin errors++; $display("FAIL rm_and_result got %h exp 00000004", rsp_result); end
    @(negedge clk);
    set_req(0, 32'd10, 32'd20, 4'd0, 5'd0);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_grant_b got %b exp 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_valid got %b exp 00", rsp_valid); end
    checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL rm_result got %h exp 0", rsp_result); end
    checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL rm_zero got %b exp 0", rsp_zero); end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_after_valid%0d got %b exp 00", c, rsp_valid); end
    end
    @(negedge clk);
    set_req(0, 32'd10, 32'd20, 4'd0, 5'd0);
    set_req(1, 32'd1, 32'd1, 4'd0, 5'd0);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_ptr_grant got %b exp 01", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    checks++; if (rsp_result !== 32'd30) begin errors++; $display("FAIL rm_post_result got %h exp 0000001e", rsp_result); end
    $display("reset_mid: post-reset grant to req0 result=%h", rsp_result);
  endtask

  task automatic test_illegal;
    @(negedge clk);
    set_req(0, 32'd1, 32'd2, 4'd12, 5'd0); rsp_ready = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL ill_grant got %b exp 01", req_ready); end
    @(negedge clk); req_valid[0] = 1'b0;
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL ill_valid got %b exp 01", rsp_valid); end
`ifdef ALU_ARB_OPCHECK_EN
    checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL ill_result got %h exp 0", rsp_result); end
    checks++; if (rsp_zero !== 1'b1) begin errors++; $display("FAIL ill_zero got %b exp 1", rsp_zero); end
    checks++; if (rsp_overflow !== 1'b0) begin errors++; $display("FAIL ill_ovf got %b exp 0", rsp_overflow); end
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL ill_err got %b exp 1", rsp_err); end
`else
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL ill_err got %b exp 0", rsp_err); end
`endif
    $display("illegal: op=12 err=%b", rsp_err);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
